// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit clock counter: runs 0..BAUD_DIV-1 and flags the last and next-to-last count.
module uart_baud_cnt #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(BAUD_DIV - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end     = (cnt_q == LAST);
  // Lets the parent register tx_done so it lands on the final STOP cycle.
  assign bit_pre_end = (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx_ctrl.sv
// Pops bytes from a standard-mode FIFO and serialises each as a UART 8N1 frame.
module fifo_uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned BAUD_DIV  = baud_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_en,
  input  logic                   fifo_empty,
  input  logic                   fifo_rd_rst_busy,
  input  logic [UART_DATA_W-1:0] fifo_dout,
  output logic                   fifo_rd_en,
  output logic                   uart_tx,
  output logic                   tx_done,
  output logic                   busy
);

  tx_state_e              state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic                   uart_tx_q, uart_tx_d;
  logic                   rd_en_q, rd_en_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   cnt_clear, bit_end, bit_pre_end;

  assign cnt_clear = (state_q == IDLE) || (state_q == RD_REQ) || (state_q == RD_WAIT);

  uart_baud_cnt #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .bit_end    (bit_end),
    .bit_pre_end(bit_pre_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      uart_tx_q <= 1'b1;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      uart_tx_q <= uart_tx_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_en && !fifo_empty && !fifo_rd_rst_busy) state_d = RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      RD_WAIT: shift_d = fifo_dout;
      START:   idx_d = '0;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins change on state entry.
  always_comb begin
    uart_tx_d = 1'b1;
    rd_en_d   = 1'b0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == STOP) && bit_pre_end;
    case (state_d)
      RD_REQ:  rd_en_d   = 1'b1;
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = shift_d[0];
      default: ;
    endcase
  end

  assign uart_tx    = uart_tx_q;
  assign fifo_rd_en = rd_en_q;
  assign tx_done    = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx_ctrl.sv
// Scoreboard bench: a FIFO model feeds the DUT, a line monitor decodes frames and checks them.
module tb_fifo_uart_tx_ctrl;

  localparam int BD    = 10;
  localparam int FRAME = 10 * BD;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty;
  logic       fifo_rd_rst_busy;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       uart_tx;
  logic       tx_done;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         done_t[$];
  int         start_t[$];

  int         cyc = 0;
  int         rd_cnt = 0;
  int         frames = 0;
  bit         mon_active = 1'b0;
  int         mon_cyc = 0;
  logic       prev_tx = 1'b1;
  logic       cur_bit = 1'b1;
  bit         glitch = 1'b0;
  logic [9:0] frame_bits = '0;

  fifo_uart_tx_ctrl #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_en           (tx_en),
    .fifo_empty      (fifo_empty),
    .fifo_rd_rst_busy(fifo_rd_rst_busy),
    .fifo_dout       (fifo_dout),
    .fifo_rd_en      (fifo_rd_en),
    .uart_tx         (uart_tx),
    .tx_done         (tx_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_frame);
    fifo_q.push_back(b);
    if (expect_frame) exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      tick();
      k++;
    end
    check(name, frames >= n, 1);
  endtask

  task automatic wait_frame_cyc(input int target, input string name);
    int k;
    k = 0;
    while (!(mon_active && mon_cyc == target) && k < 400) begin
      tick();
      k++;
    end
    check(name, mon_active && mon_cyc == target, 1);
  endtask

  // FIFO model: pops on each sampled read enable and presents the byte on fifo_dout.
  initial begin
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en) begin
        check("pop_nonempty", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Line monitor: decodes frames cycle by cycle and compares against the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_active = 1'b0;
      glitch     = 1'b0;
      prev_tx    = 1'b1;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (!mon_active) begin
        if (prev_tx && !uart_tx) begin
          mon_active = 1'b1;
          mon_cyc    = 1;
          glitch     = 1'b0;
          start_t.push_back(cyc);
        end
      end else begin
        mon_cyc++;
      end
      check("tx_done_timing", tx_done, mon_active && (mon_cyc == FRAME));
      if (mon_active) begin
        if ((mon_cyc - 1) % BD == 0) cur_bit = uart_tx;
        else if (uart_tx !== cur_bit) glitch = 1'b1;
        if ((mon_cyc - 1) % BD == BD - 1) frame_bits[(mon_cyc - 1) / BD] = cur_bit;
        if (mon_cyc == FRAME) begin
          done_t.push_back(cyc);
          frames++;
          mon_active = 1'b0;
          check("frame_start_stop", {frame_bits[0], frame_bits[9]}, 2'b01);
          check("frame_bit_stable", glitch, 0);
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("frame_byte", frame_bits[8:1], exp_q.pop_front());
        end
      end
      prev_tx = uart_tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, f0, k;
    bit low_seen;

    rst              = 1'b1;
    tx_en            = 1'b1;
    fifo_rd_rst_busy = 1'b0;
    push(8'hA5, 1'b1);

    // Reset held with a non-empty FIFO and tx_en high.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outputs", {uart_tx, fifo_rd_en, tx_done, busy}, 4'b1000);
    end
    rst = 1'b0;
    tick();
    check("first_pop_after_reset", fifo_rd_en, 1);
    check("busy_in_rd_req", busy, 1);
    wait_frames(1, 200, "single_frame_timeout");
    repeat (5) tick();
    check("single_pop_count", rd_cnt, 1);
    check("idle_after_frame", {uart_tx, busy}, 2'b10);

    // Back-to-back frames.
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    wait_frames(3, 400, "b2b_timeout");
    repeat (5) tick();
    check("b2b_pop_count", rd_cnt, 3);
    if (done_t.size() >= 3 && start_t.size() >= 3) begin
      check("b2b_done_spacing", done_t[2] - done_t[1], FRAME + 3);
      check("b2b_start_gap", start_t[2] - done_t[1], 4);
    end else begin
      check("b2b_timestamps", done_t.size(), 3);
    end

    // Read-side reset busy blocks pops.
    fifo_rd_rst_busy = 1'b1;
    push(8'h5A, 1'b1);
    rd0 = rd_cnt;
    low_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!uart_tx) low_seen = 1'b1;
    end
    check("rst_busy_no_pop", rd_cnt, rd0);
    check("rst_busy_line_high", low_seen, 0);
    fifo_rd_rst_busy = 1'b0;
    k = 0;
    while (rd_cnt == rd0 && k < 2) begin
      tick();
      k++;
    end
    check("rst_busy_release_pop", rd_cnt, rd0 + 1);
    wait_frames(4, 200, "rst_busy_frame_timeout");

    // tx_en dropped mid-frame.
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    rd0 = rd_cnt;
    wait_frame_cyc(50, "txen_mid_frame_reach");
    tx_en = 1'b0;
    wait_frames(5, 200, "txen_frame_complete");
    repeat (150) tick();
    check("txen_no_pop", rd_cnt, rd0 + 1);
    check("txen_pending", exp_q.size(), 2);
    check("txen_idle", {uart_tx, busy}, 2'b10);
    tx_en = 1'b1;
    wait_frames(7, 400, "txen_resume_timeout");
    check("txen_resume_pops", rd_cnt, rd0 + 3);

    // Reset during DATA bit 3 of 8'h37 (bit 3 is 0).
    repeat (5) tick();
    push(8'h37, 1'b0);
    wait_frame_cyc(45, "abort_reach_bit3");
    check("abort_bit3_low", uart_tx, 0);
    rst = 1'b1;
    #1;
    check("abort_immediate", {uart_tx, busy, tx_done, fifo_rd_en}, 4'b1000);
    repeat (3) tick();
    rst = 1'b0;
    f0  = frames;
    rd0 = rd_cnt;
    repeat (150) tick();
    check("abort_no_frame", frames, f0);
    check("abort_no_pop", rd_cnt, rd0);
    check("abort_idle", {uart_tx, busy}, 2'b10);
    check("abort_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
